// File: rtl/divmmc_pkg.sv
// divmmc_pkg: shared constants and FSM encoding for the DivMMC SPI master
package divmmc_pkg;
  localparam logic [7:0] CS_PORT_DEF   = 8'hE7;
  localparam logic [7:0] DATA_PORT_DEF = 8'hEB;
  localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/divmmc_spi_if.sv
// divmmc_spi_if: Z80 I/O bus seen by the DivMMC SPI port
//  iorq/rd/wr  active-low strobes from the CPU
//  a           address low byte
//  di          CPU write data
//  dout        last received SPI byte, to the CPU read mux
//  busy        transfer in progress
interface divmmc_spi_if;
  logic       iorq, rd, wr;
  logic [7:0] a, di, dout;
  logic       busy;
  modport master (output iorq, rd, wr, a, di, input dout, busy);
  modport slave  (input iorq, rd, wr, a, di, output dout, busy);
endinterface

// File: rtl/divmmc_spi_shift8.sv
// spi_shift8: one-byte SPI mode-0 shifter with bit counter
//  clock/reset  system clock, sync active-low reset
//  cep/cen      rising/falling SPI phase enables
//  run          shifter active (owner FSM in SHIFT)
//  load         start strobe: latch tx_i and present its MSB
//  tx_i         byte to send
//  miso         serial input
//  sck/mosi     SPI clock and serial output
//  done         pulse on the cen that completes the 8th bit
//  rx           received byte
module spi_shift8 (
  input  logic       clock,
  input  logic       reset,
  input  logic       cep,
  input  logic       cen,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] tx_i,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx
);
  logic [7:0] tx_q, tx_d, rx_q, rx_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ck_q, ck_d, di_q, di_d;
  always_comb begin
    tx_d  = tx_q;
    rx_d  = rx_q;
    cnt_d = cnt_q;
    ck_d  = ck_q;
    di_d  = di_q;
    done  = run & cen & (cnt_q == 3'd7);
    if (load) begin
      tx_d = tx_i;
      di_d = tx_i[7];
    end else if (run & cep) begin
      ck_d = 1'b1;
      rx_d = {rx_q[6:0], miso};
    end else if (run & cen) begin
      ck_d  = 1'b0;
      tx_d  = tx_q << 1;
      di_d  = done ? 1'b1 : tx_q[6];
      cnt_d = cnt_q + 3'd1;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_q  <= '0;
      rx_q  <= '0;
      cnt_q <= '0;
      ck_q  <= 1'b0;
      di_q  <= 1'b1;
    end else begin
      tx_q  <= tx_d;
      rx_q  <= rx_d;
      cnt_q <= cnt_d;
      ck_q  <= ck_d;
      di_q  <= di_d;
    end
  end
  assign sck  = ck_q;
  assign mosi = di_q;
  assign rx   = rx_q;
endmodule

// File: rtl/divmmc_spi.sv
// divmmc_spi: DivMMC SPI master behind Z80 ports CS_PORT (chip select) and DATA_PORT
//  clock/reset  28 MHz system clock, sync active-low reset
//  cep/cen      7 MHz rising/falling SPI phase enables
//  bus          Z80 I/O bus (slave side)
//  spiCs        card select, active-low
//  spiCk/spiDi  SPI clock (idle low) and MOSI
//  spiDo        MISO
//  spiCs2       second card select, present only with DIVMMC_SPI_CS2_EN
module divmmc_spi
  import divmmc_pkg::*;
#(
  parameter logic [7:0] CS_PORT   = CS_PORT_DEF,
  parameter logic [7:0] DATA_PORT = DATA_PORT_DEF,
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cep,
  input  logic       cen,
  divmmc_spi_if.slave bus,
  output logic       spiCs,
  output logic       spiCk,
  output logic       spiDi,
  input  logic       spiDo
`ifdef DIVMMC_SPI_CS2_EN
  ,
  output logic       spiCs2
`endif
);
  state_t     state_q, state_d;
  logic       acc, evt, start, cs_wr, done;
  logic       prev_q, prev_d, cs_q, cs_d;
  logic [7:0] do_q, do_d, rx;
`ifdef DIVMMC_SPI_CS2_EN
  logic       cs2_q, cs2_d;
`endif
  // acc is sampled only on cen so an IN/OUT spanning several cen pulses yields one event
  always_comb begin
    acc     = !bus.iorq & (!bus.rd | !bus.wr);
    evt     = cen & acc & !prev_q;
    prev_d  = cen ? acc : prev_q;
    cs_wr   = evt & !bus.wr & (bus.a == CS_PORT);
    cs_d    = cs_wr ? bus.di[0] : cs_q;
    start   = evt & (bus.a == DATA_PORT) & (state_q == IDLE);
    state_d = start ? SHIFT : done ? IDLE : state_q;
    do_d    = done ? rx : do_q;
`ifdef DIVMMC_SPI_CS2_EN
    cs2_d   = cs_wr ? bus.di[1] : cs2_q;
`endif
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      cs_q    <= 1'b1;
      do_q    <= 8'hFF;
`ifdef DIVMMC_SPI_CS2_EN
      cs2_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cs_q    <= cs_d;
      do_q    <= do_d;
`ifdef DIVMMC_SPI_CS2_EN
      cs2_q   <= cs2_d;
`endif
    end
  end
  // a read starts a transfer too, clocking out IDLE_BYTE
  spi_shift8 u_shift (
    .clock (clock),
    .reset (reset),
    .cep   (cep),
    .cen   (cen),
    .run   (state_q == SHIFT),
    .load  (start),
    .tx_i  (bus.wr ? IDLE_BYTE : bus.di),
    .miso  (spiDo),
    .sck   (spiCk),
    .mosi  (spiDi),
    .done  (done),
    .rx    (rx)
  );
  assign spiCs    = cs_q;
  assign bus.dout = do_q;
  assign bus.busy = (state_q == SHIFT);
`ifdef DIVMMC_SPI_CS2_EN
  assign spiCs2   = cs2_q;
`endif
endmodule
